// File: rtl/warface_pkg.sv
// Shared types and constants for the Warface mapper CPU-side stages:
// timer state encoding, default counter width, CTRL bit positions and
// register indices decoded from the CPU write window.
package warface_pkg;

  localparam int COUNTER_W_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

  // CTRL register bit positions.
  localparam int CTRL_START_BIT  = 7;
  localparam int CTRL_REPEAT_BIT = 6;
  localparam int CTRL_ACK_BIT    = 5;

  // Register index selected by CPU A0 inside the timer window.
  typedef enum logic {
    REG_RELOAD_LO = 1'b0,
    REG_CTRL      = 1'b1
  } reg_idx_t;

endpackage

// File: rtl/warface_irq_timer_if.sv
// CPU write-window bus as seen by the Warface mapper stages.
// master: the CPU side (drives everything); slave: a mapper register stage.
interface warface_irq_timer_if;

  logic       romsel;
  logic       cpu_rw;
  logic       cpu_a0;
  logic       cpu_a1;
  logic       cpu_a13;
  logic       cpu_a14;
  logic [7:0] cpu_data;

  modport master (
    output romsel, cpu_rw, cpu_a0, cpu_a1, cpu_a13, cpu_a14, cpu_data
  );

  modport slave (
    input romsel, cpu_rw, cpu_a0, cpu_a1, cpu_a13, cpu_a14, cpu_data
  );

endinterface

// File: rtl/warface_cpu_wdec.sv
// CPU write decoder for the $E000-$FFFF window with A1=1: produces the
// write strobe and the register index (A0). Writes with A1=0 belong to the
// bank registers and do not strobe here.
module warface_cpu_wdec
  import warface_pkg::*;
(
  warface_irq_timer_if.slave bus,
  output logic               wr_stb,
  output reg_idx_t           reg_idx
);

  // Combinational decode of a CPU write into this register window.
  always_comb begin
    wr_stb  = !bus.romsel && !bus.cpu_rw && bus.cpu_a14 && bus.cpu_a13 && bus.cpu_a1;
    reg_idx = reg_idx_t'(bus.cpu_a0);
  end

endmodule

// File: rtl/warface_irq_timer.sv
// Warface mapper interval-timer IRQ unit. Counts M2 falling edges from a
// programmable reload, raises a sticky pending flag on expiry and pulls the
// open-drain irq line low while pending. Reload 0 means 2^COUNTER_W cycles.
// Optional feature: define WARFACE_IRQ_REPEAT_EN to build the auto-repeat
// mode bit (CTRL bit6); otherwise every expiry is one-shot.
module warface_irq_timer
  import warface_pkg::*;
#(
  parameter int COUNTER_W = COUNTER_W_DEFAULT
) (
  input  logic               m2,
  input  logic               reset,
  warface_irq_timer_if.slave bus,
  output wire                irq,
  output logic               irq_pending
);

  localparam int HI_W = COUNTER_W - 8;

  typedef logic [COUNTER_W-1:0] count_t;

  timer_state_t   state, state_n;
  count_t         counter, counter_n;
  count_t         reload, reload_n;
  logic           pending, pending_n;
  logic           rpt_on;
  logic           wr_stb;
  reg_idx_t       reg_idx;
  logic           lo_wr, ctrl_wr, expire;
  logic [7:0]     data;
  logic [HI_W-1:0] hi_field;
  logic           unused_data;

  warface_cpu_wdec u_wdec (
    .bus     (bus),
    .wr_stb  (wr_stb),
    .reg_idx (reg_idx)
  );

  assign data        = bus.cpu_data;
  assign hi_field    = HI_W'(data);
  assign lo_wr       = wr_stb && (reg_idx == REG_RELOAD_LO);
  assign ctrl_wr     = wr_stb && (reg_idx == REG_CTRL);
  assign unused_data = ^data;

`ifdef WARFACE_IRQ_REPEAT_EN
  logic rpt_q;

  // Auto-repeat mode bit, relatched on every CTRL write.
  always_ff @(negedge m2 or posedge reset) begin
    if (reset) begin
      rpt_q <= 1'b0;
    end else if (ctrl_wr) begin
      rpt_q <= data[CTRL_REPEAT_BIT];
    end
  end

  assign rpt_on = rpt_q;
`else
  assign rpt_on = 1'b0;
`endif

  // State, counter, reload and pending registers, updated on falling M2.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(negedge m2 or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      reload  <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_n;
      counter <= counter_n;
      reload  <= reload_n;
      pending <= pending_n;
    end
  end

  // Next-state logic: register writes, countdown, expiry, CTRL override.
  // NOTE: every output gets a hold default first so no path infers a latch.
  always_comb begin
    state_n   = state;
    counter_n = counter;
    reload_n  = reload;
    pending_n = pending;

    // A same-edge reload write is visible to an expiry reload and a START.
    if (lo_wr) begin
      reload_n[7:0] = data;
    end
    if (ctrl_wr) begin
      reload_n[COUNTER_W-1:8] = hi_field;
    end

    expire = (state == RUN) && (counter == COUNTER_W'(1));

    if (state == RUN) begin
      // Modulo decrement: a zero reload wraps to all-ones on the first step.
      counter_n = counter - COUNTER_W'(1);
      if (expire) begin
        pending_n = 1'b1;
        if (rpt_on) begin
          counter_n = reload_n;
        end else begin
          state_n = DONE;
        end
      end
    end

    // CTRL write wins over a same-edge expiry; it always clears pending.
    if (ctrl_wr) begin
      pending_n = 1'b0;
      if (data[CTRL_START_BIT]) begin
        counter_n = reload_n;
        state_n   = RUN;
      end else if (!data[CTRL_ACK_BIT]) begin
        state_n = IDLE;
      end
    end
  end

  assign irq_pending = pending;
  assign irq         = pending ? 1'b0 : 1'bz;

endmodule

// File: doc/warface_irq_timer.md
# warface_irq_timer

- CPU-side interval-timer IRQ unit for the Warface cartridge mapper.
- Sits beside the bank/CHR register stage on the same CPU write window and drives the shared open-drain `irq` line.
- Replaces the mapper's fixed 4095-cycle one-shot with a programmable 12-bit reload, an explicit acknowledge, and optional auto-repeat.
- Counts M2 cycles so game code can time mid-frame raster effects independently of PPU activity.

## Interface
Parameters:
- `COUNTER_W`, 12, counter and reload width; `COUNTER_W` ≥ 9 (reload high field is `COUNTER_W-8` bits).

Ports:
- `m2` input 1: CPU M2 clock; all state updates on falling edge of `m2`.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `romsel` input 1: CPU /ROMSEL, low = $8000-$FFFF.
- `cpu_rw` input 1: CPU R/W, low = write.
- `cpu_a0`, `cpu_a1`, `cpu_a13`, `cpu_a14` input 1 each: CPU address bits.
- `cpu_data` input 8: CPU data bus.
- `irq` output 1: open-drain; driven 0 while pending, else Z.
- `irq_pending` output 1: internal flag copy for the neighbouring mapper stage and the bench.

## Operation
- Write strobe: `!romsel && !cpu_rw && cpu_a14 && cpu_a13 && cpu_a1` at a falling `m2`. Writes with `cpu_a1=0` belong to the bank registers and are ignored here.
- RELOAD_LO (`a0=0`): `reload[7:0] <= data`. No effect on a running count.
- CTRL (`a0=1`):
  - bits[3:0] → `reload[COUNTER_W-1:8]`.
  - bit7 START: 1 = `counter <= new reload`, state RUN, pending cleared; 0 = state IDLE, pending cleared.
  - bit6 REPEAT: latched mode bit.
  - bit5 ACK: when bit7=0, clears pending only. In RUN, any CTRL write clears pending.
- Reload value 0 means 2^COUNTER_W cycles.
- States:
  - IDLE: counter holds its value.
  - RUN: counter decrements by 1 each `m2` falling edge. On the edge where counter goes 1→0, set pending, then:
    - REPEAT=1 and REPEAT_EN built: counter ← reload, stay RUN.
    - Otherwise: go to DONE.
  - DONE: counter holds 0; pending stays until CTRL write or reset. A CTRL write with START=1 re-arms.
- Pending is sticky. Expiry while already pending keeps it set; there is no overflow count.
- Counter arithmetic is modulo 2^COUNTER_W. Reload 0 loads all-zero and the first decrement wraps to all-ones, giving 2^COUNTER_W cycles.

## Timing
- Reset values: state IDLE, counter 0, reload 0, REPEAT 0, pending 0, `irq` = Z, `irq_pending` 0.
- Latency: START write at falling edge N → pending set at edge N+R (R = reload, or 2^COUNTER_W for 0). `irq` goes low combinationally from pending, no extra cycle.
- Repeat period is exactly R cycles edge-to-edge. Reload register writes during RUN take effect at the next expiry reload.
- Expiry and CTRL write on the same edge: the write wins (START=1 reloads and clears pending, START=0 idles and clears pending).
- Expiry and RELOAD_LO write on the same edge: the reload uses the new low byte.
- `reset` asserted mid-count: immediate return to reset values. Counting resumes only after a new START.

## Configuration
- `WARFACE_IRQ_REPEAT_EN` defined: CTRL bit6 is latched and auto-reload is active as above.
- Undefined: bit6 is ignored, the REPEAT flop is not built, and every expiry goes to DONE (pure one-shot).

## Structure
- `warface_pkg`: state enum (IDLE, RUN, DONE), `COUNTER_W` default, CTRL bit-position constants (START=7, REPEAT=6, ACK=5), register index constants (RELOAD_LO=0, CTRL=1).
- One sub-module, `warface_cpu_wdec`: decodes the write strobe and register index from romsel/rw/address. Shared later with the bank-register stage.
- Counter/state logic stays in `warface_irq_timer`.

## Test plan
- Reset, write RELOAD_LO=0x10, CTRL=0x80 → `irq` low exactly 16 falling edges after the CTRL edge; stays low 100 more cycles; CTRL=0x20 releases it to Z.
- Reload 0x000, START → pending after 4096 cycles, not before.
- With `WARFACE_IRQ_REPEAT_EN`: reload 0x005, CTRL=0xC0, ACK after each fire → pending at +5, +10, +15. Without the macro: only at +5, then DONE.
- CTRL=0x80 written on the expiry edge of a running count → pending stays 0 and the count restarts from the new reload.
- `reset` pulse at count 3 of 10 → `irq` Z immediately; no IRQ for 50 cycles afterwards.
- Write with `cpu_a1=0` or `romsel=1` → reload and state unchanged, no IRQ.
